// File: rtl/otter_enc_pkg.sv
// Shared types and constants for the OTTER instruction encoder and the loader front end.
package otter_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] STORE  = 7'h23;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One packed instruction word and the flags that travel with it.
    typedef struct packed {
        logic [31:0] instr;
        logic        range_err;
        logic        align_err;
    } enc_word_t;

endpackage

// File: rtl/imm_range_check.sv
// Checks whether an immediate fits the selected format's field and whether the
// format silently drops any nonzero low-order bits.
module imm_range_check
    import otter_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        range_err,
    output logic        align_err
);

    // A field is representable when every bit above its sign bit copies that sign.
    logic i_s_bad;
    logic b_bad;
    logic j_bad;

    assign i_s_bad = !((&imm[31:11]) || !(|imm[31:11]));
    assign b_bad   = !((&imm[31:12]) || !(|imm[31:12]));
    assign j_bad   = !((&imm[31:20]) || !(|imm[31:20]));

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        range_err = 1'b0;
        align_err = 1'b0;
        case (fmt)
            FMT_R: ;
            FMT_I, FMT_S: range_err = i_s_bad;
            FMT_B: begin
                range_err = b_bad;
                align_err = imm[0];
            end
            FMT_U: align_err = |imm[11:0];
            FMT_J: begin
                range_err = j_bad;
                align_err = imm[0];
            end
            default: range_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields plus a signed immediate into an instruction word,
// behind a single registered valid/ready stage with a saturating error counter.
module instr_encoder
    import otter_enc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 range_err,
    output logic                 align_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic      chk_range;
    logic      chk_align;
    logic      accept;
    enc_word_t nxt;
    enc_word_t out_q;

    imm_range_check u_check (
        .fmt       (fmt),
        .imm       (imm),
        .range_err (chk_range),
        .align_err (chk_align)
    );

    // The stage can take a new word whenever it is empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        nxt.instr     = NOP_INSTR;
        nxt.range_err = chk_range;
        nxt.align_err = chk_align;
        case (fmt)
            FMT_R: nxt.instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: nxt.instr = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: nxt.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: nxt.instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                                imm[4:1], imm[11], opcode};
            FMT_U: nxt.instr = {imm[31:12], rd, opcode};
            FMT_J: nxt.instr = {imm[20], imm[10:1], imm[11], imm[19:12],
                                rd, opcode};
            default: nxt.instr = NOP_INSTR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && (chk_range || chk_align) && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_ONE;
        end
    end

    assign instr     = out_q.instr;
    assign range_err = out_q.range_err;
    assign align_err = out_q.align_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed spec vectors, backpressure,
// saturation and async reset, then randomized traffic against a reference model.
module tb_instr_encoder;
    import otter_enc_pkg::*;

    localparam int CW = 2;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic          range_err;
    logic          align_err;
    logic [CW-1:0] err_count;

    instr_encoder #(.ERR_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .range_err (range_err),
        .align_err (align_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        rerr;
        logic        aerr;
        logic [2:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    // Reference encoder: ranges as plain signed-integer bounds, packing from the format tables.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                   input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] im);
        exp_t e;
        longint v;
        v = longint'($signed(im));
        e.fmt = f;
        e.imm = im;
        e.rerr = 1'b0;
        e.aerr = 1'b0;
        case (f)
            3'd0: e.instr = {f7, s2, s1, f3, d, op};
            3'd1: begin
                e.instr = {im[11:0], s1, f3, d, op};
                e.rerr = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                e.instr = {im[11:5], s2, s1, f3, im[4:0], op};
                e.rerr = (v < -2048) || (v > 2047);
            end
            3'd3: begin
                e.instr = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
                e.rerr = (v < -4096) || (v > 4095);
                e.aerr = (v % 2) != 0;
            end
            3'd4: begin
                e.instr = {im[31:12], d, op};
                e.aerr = (im % 32'd4096) != 0;
            end
            3'd5: begin
                e.instr = {im[20], im[10:1], im[11], im[19:12], d, op};
                e.rerr = (v < -1048576) || (v > 1048575);
                e.aerr = (v % 2) != 0;
            end
            default: begin
                e.instr = 32'h0000_0013;
                e.rerr = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Immediate generator: what a decoder recovers from a word of the given format.
    function automatic logic [31:0] decode_imm(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd1: return {{20{w[31]}}, w[31:20]};
            3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4: return {w[31:12], 12'b0};
            3'd5: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    exp_t        q[$];
    int unsigned m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        logic m_ready;
        logic acc;
        exp_t e;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            m_ready = (q.size() == 0) || out_ready;
            acc = in_valid && m_ready;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                q.push_back(e);
                if ((e.rerr || e.aerr) && m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", in_ready, (q.size() == 0) || out_ready);
            check("out_valid", out_valid, q.size() != 0);
            check("err_count", err_count, m_cnt);
            if (q.size() != 0 && out_valid) begin
                check("instr", instr, q[0].instr);
                check("range_err", range_err, q[0].rerr);
                check("align_err", align_err, q[0].aerr);
                if (!q[0].rerr && !q[0].aerr && q[0].fmt >= 3'd1 && q[0].fmt <= 3'd5)
                    check("round_trip", decode_imm(q[0].fmt, instr), q[0].imm);
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        logic acc;
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n >= 50) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", n);
                break;
            end
        end
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im);
        drive(f, op, d, s1, s2, f3, f7, im);
        wait_accept();
    endtask

    function automatic logic [31:0] rand_imm();
        int bnd[6];
        int b;
        bnd = '{2047, -2048, 4094, -4096, 1048574, -1048576};
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: begin b = int'($urandom_range(0, 8000)) - 4000; return b; end
            2: begin
                b = bnd[$urandom_range(0, 5)] + int'($urandom_range(0, 3)) - 1;
                return b;
            end
            3: return $urandom & 32'hFFFF_F000;
            4: begin
                b = (int'($urandom_range(0, 2200000)) - 1100000) & ~1;
                return b;
            end
            default: return $urandom_range(0, 63);
        endcase
    endfunction

    initial begin
        exp_t e;
        logic [31:0] hold;
        int c0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;

        // Pin the reference model to hand-computed words.
        e = model(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        check("model_i", e.instr, 32'hFFF0_0093);
        e = model(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        check("model_b", e.instr, 32'hFE20_8EE3);
        e = model(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        check("model_u", e.instr, 32'h1234_52B7);
        check("model_u_align", e.aerr, 1'b1);
        e = model(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        check("model_j_range", e.rerr, 1'b1);
        e = model(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'h0);
        check("model_nop", e.instr, 32'h0000_0013);

        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_range", range_err, 1'b0);
        check("rst_align", align_err, 1'b0);
        check("rst_err_count", err_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk);
        #1;

        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        check("i_instr", instr, 32'hFFF0_0093);
        check("i_flags", {range_err, align_err}, 2'b00);

        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        in_valid = 1'b0;
        check("b_instr", instr, 32'hFE20_8EE3);
        check("b_flags", {range_err, align_err}, 2'b00);

        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        check("u_instr", instr, 32'h1234_52B7);
        check("u_flags", {range_err, align_err}, 2'b00);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        check("u_bad_instr", instr, 32'h1234_52B7);
        check("u_bad_flags", {range_err, align_err}, 2'b01);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
        in_valid = 1'b0;
        check("j_range", range_err, 1'b1);
        check("err_count_two", err_count, 2);

        // Backpressure: two words offered while the consumer stalls.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hAAAA_A000);
        drive(3'd4, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h5555_5000);
        hold = instr;
        check("bp_first", instr, 32'hAAAA_A0B7);
        check("bp_in_ready", in_ready, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("bp_stable", instr, hold);
            check("bp_in_ready_hold", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        check("bp_second", instr, 32'h5555_5137);
        check("bp_second_valid", out_valid, 1'b1);

        // Full-throughput streaming.
        c0 = cyc;
        for (int i = 0; i < 10; i++)
            send(3'd1, 7'h13, 5'(i + 1), 5'(i), 5'd0, 3'd0, 7'd0, 32'(i * 100 - 300));
        in_valid = 1'b0;
        check("stream_cycles", 32'(cyc - c0), 32'd10);

        // Saturation with illegal formats, then async reset while a word is pending.
        for (int i = 0; i < 6; i++)
            send(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd0, 32'(i));
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("sat_instr", instr, 32'h0000_0013);
        check("sat_range", range_err, 1'b1);
        check("sat_count", err_count, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_err_count", err_count, 0);
        check("async_instr", instr, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("no_representation", out_valid, 1'b0);

        // Randomized traffic with periodic resets so the narrow counter keeps moving.
        for (int i = 0; i < 800; i++) begin
            if (i % 60 == 59) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            in_valid  = ($urandom_range(0, 2) != 0);
            fmt       = 3'($urandom_range(0, 7));
            opcode    = 7'($urandom);
            rd        = 5'($urandom);
            rs1       = 5'($urandom);
            rs2       = 5'($urandom);
            funct3    = 3'($urandom);
            funct7    = 7'($urandom);
            imm       = rand_imm();
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("end_idle", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
